// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised up/down modulo counter with prescaler,
// synchronous clear, parallel load (clamped to MAX_VAL), wrap or saturate
// mode, and registered step/wrap/pinned flags for cascading.
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = (32'sd2 ** WIDTH) - 32'sd1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             step,
  output logic             wrap,
  output logic             pinned
);

  // A prescaler of 1 still gets a one-bit counter that simply never leaves 0.
  localparam int               PC_W    = (PRESCALE > 32'sd1) ? $clog2(PRESCALE) : 32'sd1;
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] CNT_ZRO = {WIDTH{1'b0}};
  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PRESCALE - 32'sd1);
  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1'b1);
  localparam logic [PC_W-1:0]  PC_ZRO  = {PC_W{1'b0}};
  localparam logic             SAT     = (SATURATE != 32'sd0);

  logic [WIDTH-1:0] cnt_r, cnt_nxt_s, load_clamp_s;
  logic [PC_W-1:0]  pc_r, pc_nxt_s;
  logic             step_r, step_nxt_s;
  logic             wrap_r, wrap_nxt_s;
  logic             pinned_r, pinned_nxt_s;
  logic             at_max_s, at_zero_s;

  // Next-state: clr > load > prescaled count step; bound checks precede arithmetic.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    pc_nxt_s     = pc_r;
    step_nxt_s   = 1'b0;
    wrap_nxt_s   = 1'b0;
    pinned_nxt_s = pinned_r;
    at_max_s     = (cnt_r == MAX_V);
    at_zero_s    = (cnt_r == CNT_ZRO);
    load_clamp_s = (load_val > MAX_V) ? MAX_V : load_val;
    if (clr) begin
      cnt_nxt_s    = CNT_ZRO;
      pc_nxt_s     = PC_ZRO;
      pinned_nxt_s = 1'b0;
    end else if (load) begin
      cnt_nxt_s    = load_clamp_s;
      pc_nxt_s     = PC_ZRO;
      pinned_nxt_s = 1'b0;
    end else if (en) begin
      if (pc_r == PC_LAST) begin
        pc_nxt_s   = PC_ZRO;
        step_nxt_s = 1'b1;
        if (up_dn) begin
          if (!at_max_s) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end else if (SAT) begin
            pinned_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s  = CNT_ZRO;
            wrap_nxt_s = 1'b1;
          end
        end else begin
          if (!at_zero_s) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
          end else if (SAT) begin
            pinned_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s  = MAX_V;
            wrap_nxt_s = 1'b1;
          end
        end
      end else begin
        pc_nxt_s = pc_r + PC_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
      pc_nxt_s  = pc_r;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= CNT_ZRO;
      pc_r     <= PC_ZRO;
      step_r   <= 1'b0;
      wrap_r   <= 1'b0;
      pinned_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      pc_r     <= pc_nxt_s;
      step_r   <= step_nxt_s;
      wrap_r   <= wrap_nxt_s;
      pinned_r <= pinned_nxt_s;
    end
  end

  assign out    = cnt_r;
  assign step   = step_r;
  assign wrap   = wrap_r;
  assign pinned = pinned_r;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed scoreboard bench. Expected
// {out, step, wrap, pinned} tuples are queued as stimulus is set up and
// compared one cycle later, #1 after the rising edge.
module tb_updown_mod_counter;

  typedef struct {
    int          idx;
    logic [10:0] exp;
    string       tag;
  } exp_t;

  logic       clk;
  logic [6:0] rst_v, en_v, up_v, clr_v, load_v;
  logic [7:0] lv;
  logic [7:0] out0, out3, out4;
  logic [3:0] out1, out2, out5, out6;
  logic       st [7];
  logic       wr [7];
  logic       pn [7];
  exp_t       sb_q[$];
  int         checks;
  int         errors;

  // u0: default 8-bit free counter
  updown_mod_counter u0 (.clk(clk), .rst(rst_v[0]), .en(en_v[0]), .up_dn(up_v[0]), .clr(clr_v[0]),
    .load(load_v[0]), .load_val(lv), .out(out0), .step(st[0]), .wrap(wr[0]), .pinned(pn[0]));
  // u1: 4-bit, modulo 10, wrapping
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9)) u1 (.clk(clk), .rst(rst_v[1]), .en(en_v[1]),
    .up_dn(up_v[1]), .clr(clr_v[1]), .load(load_v[1]), .load_val(lv[3:0]), .out(out1),
    .step(st[1]), .wrap(wr[1]), .pinned(pn[1]));
  // u2: 4-bit, range 0..9, saturating
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) u2 (.clk(clk), .rst(rst_v[2]),
    .en(en_v[2]), .up_dn(up_v[2]), .clr(clr_v[2]), .load(load_v[2]), .load_val(lv[3:0]),
    .out(out2), .step(st[2]), .wrap(wr[2]), .pinned(pn[2]));
  // u3: 8-bit, prescale by 3
  updown_mod_counter #(.PRESCALE(3)) u3 (.clk(clk), .rst(rst_v[3]), .en(en_v[3]), .up_dn(up_v[3]),
    .clr(clr_v[3]), .load(load_v[3]), .load_val(lv), .out(out3), .step(st[3]), .wrap(wr[3]),
    .pinned(pn[3]));
  // u4: 8-bit, range 0..99
  updown_mod_counter #(.MAX_VAL(99)) u4 (.clk(clk), .rst(rst_v[4]), .en(en_v[4]), .up_dn(up_v[4]),
    .clr(clr_v[4]), .load(load_v[4]), .load_val(lv), .out(out4), .step(st[4]), .wrap(wr[4]),
    .pinned(pn[4]));
  // u5 (low digit) -> u6 (high digit) decade chain
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9)) u5 (.clk(clk), .rst(rst_v[5]), .en(en_v[5]),
    .up_dn(up_v[5]), .clr(clr_v[5]), .load(load_v[5]), .load_val(lv[3:0]), .out(out5),
    .step(st[5]), .wrap(wr[5]), .pinned(pn[5]));
  updown_mod_counter #(.WIDTH(4), .MAX_VAL(9)) u6 (.clk(clk), .rst(rst_v[6]), .en(wr[5]),
    .up_dn(up_v[6]), .clr(clr_v[6]), .load(load_v[6]), .load_val(lv[3:0]), .out(out6),
    .step(st[6]), .wrap(wr[6]), .pinned(pn[6]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] obs(input int i);
    case (i)
      0: obs = {out0, st[0], wr[0], pn[0]};
      1: obs = {4'h0, out1, st[1], wr[1], pn[1]};
      2: obs = {4'h0, out2, st[2], wr[2], pn[2]};
      3: obs = {out3, st[3], wr[3], pn[3]};
      4: obs = {out4, st[4], wr[4], pn[4]};
      5: obs = {4'h0, out5, st[5], wr[5], pn[5]};
      6: obs = {4'h0, out6, st[6], wr[6], pn[6]};
      default: obs = 11'h7FF;
    endcase
  endfunction

  task automatic push(input int i, input logic [7:0] o, input logic s, input logic w,
                      input logic p, input string tag);
    exp_t e;
    e.idx = i;
    e.exp = {o, s, w, p};
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Advance one edge, then check every queued expectation against the DUTs.
  task automatic cyc();
    exp_t e;
    logic [10:0] o;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = obs(e.idx);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s u%0d: observed out=%0d step=%b wrap=%b pinned=%b expected out=%0d step=%b wrap=%b pinned=%b",
               e.tag, e.idx, o[10:3], o[2], o[1], o[0], e.exp[10:3], e.exp[2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_v  = 7'h7F;
    en_v   = 7'h7F;
    up_v   = 7'h7F;
    clr_v  = 7'h00;
    load_v = 7'h00;
    lv     = 8'd0;

    // Reset with en=1 held for two clocks.
    repeat (2) begin
      for (int i = 0; i < 7; i++) push(i, 8'd0, 1'b0, 1'b0, 1'b0, "reset");
      cyc();
    end

    // Free count after reset release.
    rst_v[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      push(0, 8'(k), 1'b1, 1'b0, 1'b0, "t1_count_up");
      cyc();
    end

    // Modulo-10 wrap up and down.
    rst_v[1] = 1'b0; load_v[1] = 1'b1; lv = 8'd8;
    push(1, 8'd8, 1'b0, 1'b0, 1'b0, "t2_load8"); cyc();
    load_v[1] = 1'b0;
    push(1, 8'd9, 1'b1, 1'b0, 1'b0, "t2_up_to_9"); cyc();
    push(1, 8'd0, 1'b1, 1'b1, 1'b0, "t2_wrap_up"); cyc();
    push(1, 8'd1, 1'b1, 1'b0, 1'b0, "t2_after_wrap"); cyc();
    up_v[1] = 1'b0;
    push(1, 8'd0, 1'b1, 1'b0, 1'b0, "t2_down_to_0"); cyc();
    push(1, 8'd9, 1'b1, 1'b1, 1'b0, "t2_wrap_down"); cyc();
    // Reset on the same edge that would wrap 9 -> 0.
    up_v[1] = 1'b1; rst_v[1] = 1'b1;
    push(1, 8'd0, 1'b0, 1'b0, 1'b0, "t6_rst_on_wrap"); cyc();
    rst_v[1] = 1'b0;
    push(1, 8'd1, 1'b1, 1'b0, 1'b0, "t2_step_after_rst"); cyc();
    en_v[1] = 1'b0;
    push(1, 8'd1, 1'b0, 1'b0, 1'b0, "t2_en_off_hold"); cyc();

    // Saturating bounds and sticky pinned.
    rst_v[2] = 1'b0; load_v[2] = 1'b1; lv = 8'd9;
    push(2, 8'd9, 1'b0, 1'b0, 1'b0, "t3_load9"); cyc();
    load_v[2] = 1'b0;
    repeat (3) begin
      push(2, 8'd9, 1'b1, 1'b0, 1'b1, "t3_sat_hold_up"); cyc();
    end
    en_v[2] = 1'b0;
    push(2, 8'd9, 1'b0, 1'b0, 1'b1, "t3_pinned_sticky"); cyc();
    load_v[2] = 1'b1; lv = 8'd4;
    push(2, 8'd4, 1'b0, 1'b0, 1'b0, "t3_load_unpins"); cyc();
    load_v[2] = 1'b0; en_v[2] = 1'b1;
    push(2, 8'd5, 1'b1, 1'b0, 1'b0, "t3_step_from_4"); cyc();
    load_v[2] = 1'b1; lv = 8'd0;
    push(2, 8'd0, 1'b0, 1'b0, 1'b0, "t3_load0"); cyc();
    load_v[2] = 1'b0; up_v[2] = 1'b0;
    push(2, 8'd0, 1'b1, 1'b0, 1'b1, "t3_sat_hold_down"); cyc();
    clr_v[2] = 1'b1;
    push(2, 8'd0, 1'b0, 1'b0, 1'b0, "t3_clr_unpins"); cyc();
    clr_v[2] = 1'b0; rst_v[2] = 1'b1;

    // Prescale by 3, with a 2-clock enable gap mid-prescale.
    rst_v[3] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      push(3, 8'(k / 3), (k % 3) == 0, 1'b0, 1'b0, "t4_prescale");
      cyc();
    end
    en_v[3] = 1'b0;
    repeat (2) begin
      push(3, 8'd2, 1'b0, 1'b0, 1'b0, "t4_en_gap_hold"); cyc();
    end
    en_v[3] = 1'b1;
    push(3, 8'd2, 1'b0, 1'b0, 1'b0, "t4_resume_no_step"); cyc();
    push(3, 8'd3, 1'b1, 1'b0, 1'b0, "t4_delayed_step"); cyc();
    push(3, 8'd3, 1'b0, 1'b0, 1'b0, "t4_partial_prescale"); cyc();
    load_v[3] = 1'b1; lv = 8'd7;
    push(3, 8'd7, 1'b0, 1'b0, 1'b0, "t4_load_discards_pc"); cyc();
    load_v[3] = 1'b0;
    push(3, 8'd7, 1'b0, 1'b0, 1'b0, "t4_after_load_1"); cyc();
    push(3, 8'd7, 1'b0, 1'b0, 1'b0, "t4_after_load_2"); cyc();
    push(3, 8'd8, 1'b1, 1'b0, 1'b0, "t4_after_load_step"); cyc();

    // clr over load, load clamp, wrap at 99.
    rst_v[4] = 1'b0; en_v[4] = 1'b0; load_v[4] = 1'b1; lv = 8'd50;
    push(4, 8'd50, 1'b0, 1'b0, 1'b0, "t5_load50"); cyc();
    clr_v[4] = 1'b1; lv = 8'd5;
    push(4, 8'd0, 1'b0, 1'b0, 1'b0, "t5_clr_over_load"); cyc();
    clr_v[4] = 1'b0; lv = 8'd200;
    push(4, 8'd99, 1'b0, 1'b0, 1'b0, "t5_load_clamp"); cyc();
    load_v[4] = 1'b0; en_v[4] = 1'b1;
    push(4, 8'd0, 1'b1, 1'b1, 1'b0, "t5_wrap_at_99"); cyc();

    // Decade chain: the high digit advances one clock after the low digit wraps.
    rst_v[5] = 1'b0; rst_v[6] = 1'b0;
    for (int k = 1; k <= 101; k++) begin
      int  lo, hi;
      logic s6, w6;
      lo = k % 10;
      hi = ((k - 1) / 10) % 10;
      s6 = (k > 1) && (((k - 1) % 10) == 0);
      w6 = s6 && (hi == 0);
      push(5, 8'(lo), 1'b1, (lo == 0), 1'b0, "t6_chain_low");
      push(6, 8'(hi), s6, w6, 1'b0, "t6_chain_high");
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
